// File: rtl/tx_cmd_nib_if.sv
// ----------------------------------------------------------------------------
// tx_cmd_nib_if
// Request and UART-TX handshake bundle for tx_cmd_nib.
//   i_start    : frame request from the ILA side
//   i_data     : DATA_W-bit payload, latched on accepted start
//   i_abort    : synchronous frame cancel
//   i_tx_done  : per-byte completion pulse from the UART TX
//   o_tx_start : one-cycle send request to the UART TX
//   o_tx_byte  : {ADDR, nibble} byte to send
//   o_busy     : frame in progress
//   o_done     : one-cycle end-of-frame pulse
// slave  = the serialiser itself, master = whoever drives requests/UART.
// ----------------------------------------------------------------------------
interface tx_cmd_nib_if #(
    parameter int DATA_W = 16
);
    logic              i_start;
    logic [DATA_W-1:0] i_data;
    logic              i_abort;
    logic              i_tx_done;
    logic              o_tx_start;
    logic [7:0]        o_tx_byte;
    logic              o_busy;
    logic              o_done;

    modport slave (
        input  i_start, i_data, i_abort, i_tx_done,
        output o_tx_start, o_tx_byte, o_busy, o_done
    );

    modport master (
        output i_start, i_data, i_abort, i_tx_done,
        input  o_tx_start, o_tx_byte, o_busy, o_done
    );
endinterface

// File: rtl/tx_cmd_nib.sv
// ----------------------------------------------------------------------------
// tx_cmd_nib
// Serialises a DATA_W-bit word into DATA_W/4 command bytes {ADDR, nibble},
// most-significant nibble first, handing one byte at a time to a UART TX and
// waiting for its per-byte completion pulse.
// Ports:
//   i_clk   : system clock, rising edge
//   i_reset : synchronous reset, active-high
//   bus     : tx_cmd_nib_if.slave (start/data/abort/tx_done in,
//             tx_start/tx_byte/busy/done out); all outputs registered
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for i_start; o_tx_byte = 0
// SEND  | o_tx_start pulse, current nibble on o_tx_byte
// WAIT  | byte held, waiting for i_tx_done from the UART
// DONE  | o_done pulse, o_busy low, start not yet accepted
// ----------------------------------------------------------------------------
module tx_cmd_nib #(
    parameter logic [3:0] ADDR   = 4'b0000,
    parameter int         DATA_W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    tx_cmd_nib_if.slave  bus
);
    localparam int NUM_NIB = DATA_W / 4;
    localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] shreg, shreg_n, shifted;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              tx_start_n, busy_n, done_n;
    logic [7:0]        tx_byte_n;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state          <= IDLE;
            shreg          <= '0;
            cnt            <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_tx_byte  <= 8'h00;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
        end else begin
            state          <= state_n;
            shreg          <= shreg_n;
            cnt            <= cnt_n;
            bus.o_tx_start <= tx_start_n;
            bus.o_tx_byte  <= tx_byte_n;
            bus.o_busy     <= busy_n;
            bus.o_done     <= done_n;
        end
    end

    // Outputs are computed for the state being entered so that they appear
    // registered in the same cycle as that state.
    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        cnt_n      = cnt;
        tx_start_n = 1'b0;
        tx_byte_n  = bus.o_tx_byte;
        busy_n     = bus.o_busy;
        done_n     = 1'b0;
        shifted    = shreg << 4;

        case (state)
            IDLE: begin
                tx_byte_n = 8'h00;
                busy_n    = 1'b0;
                // abort alongside start drops the request
                if (bus.i_start && !bus.i_abort) begin
                    state_n    = SEND;
                    shreg_n    = bus.i_data;
                    cnt_n      = CNT_W'(NUM_NIB - 1);
                    tx_start_n = 1'b1;
                    tx_byte_n  = {ADDR, bus.i_data[DATA_W-1 -: 4]};
                    busy_n     = 1'b1;
                end
            end
            SEND: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (bus.i_tx_done) begin
                    if (cnt != '0) begin
                        state_n    = SEND;
                        shreg_n    = shifted;
                        cnt_n      = cnt - CNT_W'(1);
                        tx_start_n = 1'b1;
                        tx_byte_n  = {ADDR, shifted[DATA_W-1 -: 4]};
                    end else begin
                        state_n   = DONE;
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        tx_byte_n = 8'h00;
                    end
                end
            end
            DONE: begin
                state_n   = IDLE;
                busy_n    = 1'b0;
                tx_byte_n = 8'h00;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // abort overrides everything outside IDLE, including a coincident tx_done
        if (bus.i_abort && state != IDLE) begin
            state_n    = IDLE;
            shreg_n    = '0;
            cnt_n      = '0;
            tx_start_n = 1'b0;
            tx_byte_n  = 8'h00;
            busy_n     = 1'b0;
            done_n     = 1'b0;
        end
    end
endmodule

// File: doc/tx_cmd_nib.md
Name: tx_cmd_nib

Overview:
Transmit-side counterpart of the ILA command-nibble receiver. Takes a parallel DATA_W-bit word and serialises it into a frame of command bytes for the UART transmitter. Each byte carries the fixed ADDR pattern in bits [7:4] and one data nibble in bits [3:0], most-significant nibble first. It sits between ILA status/sample logic and the UART TX, which reports per-byte completion.

Parameters:
ADDR, 4'b0000, bit pattern placed in bits [7:4] of every emitted byte.
DATA_W, 16, payload width in bits. Must be a multiple of 4 and at least 4. NUM_NIB = DATA_W/4 bytes per frame.

Ports:
i_clk  input  1  system clock; all logic is on the rising edge.
i_reset  input  1  synchronous reset, active-high.
i_start  input  1  frame request; sampled only in IDLE.
i_data  input  DATA_W  payload; latched in the cycle i_start is accepted.
i_abort  input  1  synchronous frame cancel.
i_tx_done  input  1  one-cycle pulse from the UART TX when the current byte has been fully sent.
o_tx_start  output  1  one-cycle pulse requesting the UART TX to send o_tx_byte.
o_tx_byte  output  8  byte to send, {ADDR, nibble}.
o_busy  output  1  high from the cycle after start acceptance until the cycle that returns to IDLE.
o_done  output  1  one-cycle pulse after the last byte's i_tx_done.

Behaviour:
- Reset (i_reset=1 at a clock edge): state goes to IDLE. o_tx_start=0, o_tx_byte=8'h00, o_busy=0, o_done=0. Shift register and counter are cleared. Reset has priority over every other input. Reset mid-frame discards the frame; no o_done is produced.
- All outputs are registered.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE:
  - If i_start=1 at edge N: latch i_data into the shift register, set cnt=NUM_NIB-1, go to SEND.
  - o_busy=1 from edge N onward.
  - i_start is ignored in every other state; there is no queuing.
- SEND (one cycle):
  - o_tx_start=1.
  - o_tx_byte={ADDR, shreg[DATA_W-1:DATA_W-4]}.
  - Next state is WAIT.
  - An i_tx_done arriving in SEND is ignored.
- WAIT:
  - o_tx_start=0. o_tx_byte is held stable.
  - On i_tx_done=1 with cnt!=0: shift shreg left by 4, decrement cnt, go to SEND.
  - On i_tx_done=1 with cnt==0: go to DONE.
  - With no i_tx_done, remain in WAIT indefinitely; there is no timeout.
- DONE (one cycle):
  - o_done=1 and o_busy=0.
  - Next state is IDLE.
  - i_start is not accepted in DONE; the earliest new acceptance is the first IDLE cycle.
- Timing:
  - First o_tx_start occurs 1 cycle after i_start is accepted.
  - Each later o_tx_start occurs 1 cycle after the previous byte's i_tx_done.
  - o_done occurs 1 cycle after the final i_tx_done.
- Abort: i_abort=1 in SEND, WAIT or DONE returns the block to IDLE at the next edge.
  - o_busy goes low. o_done and o_tx_start are not asserted.
  - o_tx_byte returns to 8'h00.
  - If i_abort and i_tx_done coincide, abort wins.
  - i_abort in IDLE has no effect. i_abort together with i_start in IDLE: abort wins and the start is dropped.
- o_tx_byte is 8'h00 in IDLE and DONE.
- Counter width is clog2(NUM_NIB), minimum 1 bit. Counter wrap-around never occurs.
- DATA_W=4 gives a single-byte frame: SEND, WAIT, DONE.

Test Plan:
- ADDR=4'hA, DATA_W=16, i_data=16'h1234 with i_start pulse; bench returns i_tx_done 5 cycles after each o_tx_start. Required: bytes 8'hA1, 8'hA2, 8'hA3, 8'hA4 in order, exactly 4 o_tx_start pulses, then one o_done 1 cycle after the 4th i_tx_done, with o_busy high throughout the frame.
- i_tx_done returned in the cycle immediately after o_tx_start (minimum latency). Required: SEND/WAIT alternates every 2 cycles, all 4 bytes are correct, and o_done follows.
- A second i_start with i_data=16'hFFFF during a frame of 16'h0F0F. Required: it is ignored and only bytes 8'hA0, 8'hAF, 8'hA0, 8'hAF are emitted. A start issued after o_done sends 16'hFFFF correctly.
- i_abort after the 2nd byte's o_tx_start, then an i_tx_done. Required: back in IDLE with o_busy=0, no o_done, no further o_tx_start, o_tx_byte=8'h00.
- i_reset=1 for 1 cycle while in WAIT of byte 3. Required: all outputs 0 at the next edge, and the following frame 16'hBEEF emits 8'hAB, 8'hAE, 8'hAE, 8'hAF.
- DATA_W=4, i_data=4'h7, ADDR=4'h3. Required: single byte 8'h37, then o_done 1 cycle after i_tx_done.
